// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register with jal/jmp/branch/increment update,
// a four-state fetch sequencer (IDLE, REQ, WAIT, CAPTURE) that reads one
// 16-bit instruction word from memory, and instruction field slices.
// Optional feature macro: IFU_FETCH_CNT_EN adds a saturating completed-fetch
// counter on fetch_count; without it fetch_count is tied to zero.
// Sign extension of branch_disp assumes ADDR_W >= 8.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_start,
    input  logic                pc_en,
    input  logic                branch_en,
    input  logic                jmp_en,
    input  logic                jal_en,
    input  logic [7:0]          branch_disp,
    input  logic [ADDR_W-1:0]   jump_target,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd,
    input  logic [15:0]         mem_rdata,
    output logic [15:0]         instr,
    output logic                instr_valid,
    output logic [3:0]          opCode1,
    output logic [3:0]          cond_rdest,
    output logic [3:0]          opCode2,
    output logic [3:0]          rsrc_shamt,
    output logic [7:0]          imm8,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   link_addr,
    output logic                busy,
    output logic                pc_conflict,
    output logic [15:0]         fetch_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   disp_ext;
    logic [ADDR_W-1:0]   pc_next;

    // Fetch sequencer; data is valid in WAIT, so it is captured on entry to CAPTURE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_addr  <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        state      <= REQ;
                        fetch_addr <= pc;
                    end
                end
                REQ:  state <= WAIT;
                WAIT: begin
                    state       <= CAPTURE;
                    instr       <= mem_rdata;
                    instr_valid <= 1'b1;
                end
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Next-PC selection, priority jal > jmp > branch > increment, modulo 2^ADDR_W
    always_comb begin
        pc_inc   = pc + ADDR_W'(1);
        disp_ext = ADDR_W'($signed(branch_disp));
        pc_next  = pc_inc;
        if (jal_en || jmp_en) begin
            pc_next = jump_target;
        end else if (branch_en) begin
            pc_next = pc + disp_ext;
        end
    end

    // PC, link register and sticky conflict flag; updates only while idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            link_addr   <= '0;
            pc_conflict <= 1'b0;
        end else if (pc_en) begin
            if (state == IDLE) begin
                pc <= pc_next;
                if (jal_en) begin
                    link_addr <= pc_inc;
                end
            end else begin
                pc_conflict <= 1'b1;
            end
        end
    end

`ifdef IFU_FETCH_CNT_EN
    logic [15:0] fetch_cnt;

    // Saturating count of completed fetches, bumped on entry to CAPTURE
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt <= '0;
        end else if (state == WAIT && fetch_cnt != 16'hFFFF) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt;
`else
    assign fetch_count = 16'h0000;
`endif

    assign mem_addr   = fetch_addr;
    assign mem_rd     = (state == REQ);
    assign busy       = (state != IDLE);

    assign opCode1    = instr[15:12];
    assign cond_rdest = instr[11:8];
    assign opCode2    = instr[7:4];
    assign rsrc_shamt = instr[3:0];
    assign imm8       = instr[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// stimulus, compared every cycle against a cycle-count reference model.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W = 16;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic              clk;
    logic              reset;
    logic              fetch_start;
    logic              pc_en;
    logic              branch_en;
    logic              jmp_en;
    logic              jal_en;
    logic [7:0]        branch_disp;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_rdata;
    logic [15:0]       instr;
    logic              instr_valid;
    logic [3:0]        opCode1;
    logic [3:0]        cond_rdest;
    logic [3:0]        opCode2;
    logic [3:0]        rsrc_shamt;
    logic [7:0]        imm8;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] link_addr;
    logic              busy;
    logic              pc_conflict;
    logic [15:0]       fetch_count;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_en(pc_en),
        .branch_en(branch_en), .jmp_en(jmp_en), .jal_en(jal_en),
        .branch_disp(branch_disp), .jump_target(jump_target),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .instr(instr), .instr_valid(instr_valid), .opCode1(opCode1),
        .cond_rdest(cond_rdest), .opCode2(opCode2), .rsrc_shamt(rsrc_shamt),
        .imm8(imm8), .pc(pc), .link_addr(link_addr), .busy(busy),
        .pc_conflict(pc_conflict), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Reference model: architectural values plus cycles remaining in a fetch
    logic [15:0] m_pc, m_fa, m_link, m_instr;
    logic        m_conflict;
    int          m_count;
    int          m_left;

    // Memory responder state
    logic        rd_seen;
    logic [15:0] rd_addr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'(a * 16'h9E37) ^ 16'h5A12;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, fs, pe, br, jp, jl,
                              input logic [7:0] disp, input logic [15:0] tgt);
        logic [15:0] old_pc;
        if (!rst) begin
            m_pc = RST_PC; m_fa = RST_PC; m_link = 16'h0; m_instr = 16'h0;
            m_conflict = 1'b0; m_count = 0; m_left = 0;
        end else if (m_left == 0) begin
            old_pc = m_pc;
            if (pe) begin
                if (jl) begin
                    m_pc = tgt; m_link = 16'(int'(old_pc) + 1);
                end else if (jp) begin
                    m_pc = tgt;
                end else if (br) begin
                    m_pc = 16'(int'(old_pc) + int'($signed(disp)));
                end else begin
                    m_pc = 16'(int'(old_pc) + 1);
                end
            end
            if (fs) begin
                m_fa = old_pc; m_left = 3;
            end
        end else begin
            if (pe) m_conflict = 1'b1;
            m_left--;
            if (m_left == 1) begin
                m_instr = mem_word(m_fa);
                if (m_count < 65535) m_count++;
            end
        end
    endtask

    task automatic step(input logic rst, fs, pe, br, jp, jl,
                        input logic [7:0] disp, input logic [15:0] tgt);
        logic [15:0] exp_cnt;
        reset = rst; fetch_start = fs; pc_en = pe; branch_en = br;
        jmp_en = jp; jal_en = jl; branch_disp = disp; jump_target = tgt;
        @(posedge clk);
        model_edge(rst, fs, pe, br, jp, jl, disp, tgt);
        #1;
        mem_rdata = rd_seen ? mem_word(rd_addr) : 16'($urandom);
        rd_seen = mem_rd;
        rd_addr = mem_addr;
        if (instr_valid) pulses++;
`ifdef IFU_FETCH_CNT_EN
        exp_cnt = 16'(m_count);
`else
        exp_cnt = 16'h0;
`endif
        check("pc", pc, m_pc);
        check("link_addr", link_addr, m_link);
        check("mem_addr", mem_addr, m_fa);
        check("mem_rd", mem_rd, m_left == 3);
        check("busy", busy, m_left != 0);
        check("instr_valid", instr_valid, m_left == 1);
        check("instr", instr, m_instr);
        check("fields", {opCode1, cond_rdest, opCode2, rsrc_shamt, imm8},
              {m_instr[15:12], m_instr[11:8], m_instr[7:4], m_instr[3:0], m_instr[7:0]});
        check("pc_conflict", pc_conflict, m_conflict);
        check("fetch_count", fetch_count, exp_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
    endtask

    task automatic jump_to(input logic [15:0] a);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, a);
    endtask

    initial begin
        reset = 1'b0; fetch_start = 1'b0; pc_en = 1'b0; branch_en = 1'b0;
        jmp_en = 1'b0; jal_en = 1'b0; branch_disp = 8'h0; jump_target = 16'h0;
        mem_rdata = 16'h0; rd_seen = 1'b0; rd_addr = 16'h0;
        m_pc = RST_PC; m_fa = RST_PC; m_link = 16'h0; m_instr = 16'h0;
        m_conflict = 1'b0; m_count = 0; m_left = 0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        check("rst_pc", pc, RST_PC);
        check("rst_busy", busy, 0);
        check("rst_instr", instr, 0);

        // First fetch from address 0 returns 0x5A12
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        check("f0_mem_rd", mem_rd, 1);
        check("f0_mem_addr", mem_addr, 16'h0000);
        idle(2);
        check("f0_valid", instr_valid, 1);
        check("f0_instr", instr, 16'h5A12);
        check("f0_opcode1", opCode1, 4'h5);
        check("f0_cond_rdest", cond_rdest, 4'hA);
        check("f0_imm8", imm8, 8'h12);
        idle(1);
        check("f0_done_busy", busy, 0);

        // Backward branch then plain increment
        jump_to(16'h0010);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFC, 16'h0);
        check("br_back", pc, 16'h000C);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        check("inc", pc, 16'h000D);

        // jal wins over jmp
        jump_to(16'h0020);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 16'h0300);
        check("jal_pc", pc, 16'h0300);
        check("jal_link", link_addr, 16'h0021);

        // Wrap at all-ones, then a second fetch_start during WAIT is ignored
        jump_to(16'hFFFF);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        check("wrap", pc, 16'h0000);
        pulses = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        idle(5);
        check("one_pulse", pulses, 1);

        // 0 + (-1) wraps to all-ones
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 16'h0);
        check("wrap_neg", pc, 16'hFFFF);

        // pc_en during WAIT is ignored and flagged; reset in WAIT aborts the fetch
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        idle(1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'h1234);
        check("conf_pc", pc, 16'hFFFF);
        check("conf_flag", pc_conflict, 1);
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        idle(1);
        pulses = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        idle(4);
        check("abort_pulses", pulses, 0);
        check("abort_pc", pc, RST_PC);
        check("abort_conf", pc_conflict, 0);

        // Three fetches after reset
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
            idle(3);
        end
`ifdef IFU_FETCH_CNT_EN
        check("cnt3", fetch_count, 3);
`else
        check("cnt_tied", fetch_count, 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(39) != 0, $urandom_range(2) == 0, $urandom_range(1) == 1,
                 $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                 8'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
